wb_stage: RTL
=============

Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback formatting for the 5-stage MIPS datapath.
- Captures memory-stage results on the rising edge of CLK.
- Formats load data (byte/half extraction, sign or zero extension) and selects the writeback source.
- Drives the register-file write port (A3/WD3/WE3), which commits on the following falling edge; also keeps a retired-instruction counter.

Parameters:
DATA_W, 32, datapath width (only 32 supported)
CNT_W, 32, retired-instruction counter width

Ports:
CLK  input  1  clock; capture on rising edge
RESET  input  1  asynchronous, active-high reset
STALL  input  1  hold current contents
FLUSH  input  1  squash incoming entry (priority over STALL)
in_valid  input  1  MEM stage holds a real instruction
in_reg_write  input  1  instruction writes a GPR
in_dest  input  5  destination register number
in_wb_sel  input  2  0=ALU, 1=load data, 2=PC+8 (link), 3=reserved
in_load_type  input  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, others reserved
in_addr_lo  input  2  effective address bits [1:0]
in_alu_result  input  32  ALU result
in_mem_rdata  input  32  raw data-memory word
in_pc_plus8  input  32  link address
WB_A3  output  5  register-file write address
WB_WD3  output  32  register-file write data
WB_WE3  output  1  register-file write enable
wb_valid  output  1  stage holds a valid instruction
misalign_err  output  1  held load is misaligned
retire_cnt  output  CNT_W  instructions retired

Behaviour:
- Reset (RESET=1, asynchronous) clears all state registers to 0:
  - outputs: WB_A3=0, WB_WD3=0, WB_WE3=0, wb_valid=0, misalign_err=0, retire_cnt=0.
  - Held while RESET is high, regardless of CLK.
- Rising edge of CLK, in priority order:
  - FLUSH=1: valid<=0 and reg_write<=0; other fields don't-care.
  - else STALL=1: hold all fields.
  - else: capture all in_* fields.
- Latency: one cycle. Inputs presented before edge N appear on the WB_* outputs after edge N. The register file commits them at the falling edge inside that same cycle.
- Outputs are combinational from the held registers only; there is no combinational path from in_* to any output.
- Load formatting (little-endian):
  - LW: whole word.
  - LH/LHU: halfword at bits [16*addr_lo[1]+15 : 16*addr_lo[1]]; LH sign-extends, LHU zero-extends.
  - LB/LBU: byte at bits [8*addr_lo+7 : 8*addr_lo]; LB sign-extends, LBU zero-extends.
- Misalignment, evaluated only when wb_sel=1:
  - misalign_err=1 when wb_valid=1 and either (LW with addr_lo!=0) or (LH/LHU with addr_lo[0]=1).
  - A reserved load_type also raises misalign_err.
- WB_WD3 mux:
  - sel 0 -> alu_result.
  - sel 1 -> formatted load.
  - sel 2 -> pc_plus8.
  - sel 3 -> 0.
- WB_A3 = held dest.
- WB_WE3 = wb_valid & reg_write & (dest!=0) & !misalign_err & (wb_sel!=3).
- STALL with a valid entry: WE3 stays asserted. The same value is rewritten every falling edge, which is idempotent and required.
- retire_cnt:
  - Increments by 1 on each rising edge where wb_valid=1 and STALL=0. FLUSH does not block this, because the held instruction has already committed.
  - Misaligned loads still count.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- STALL and FLUSH together: FLUSH wins; the entry becomes a bubble. The counter still obeys the STALL=0 condition, so it does not increment that edge.
- RESET mid-stall or mid-write: WE3 drops immediately (asynchronous), so no further register-file write occurs.

Decomposition:
- Shared package mips_pkg holds:
  - WB_SEL_ALU/MEM/LINK/RSVD (2-bit) constants.
  - LD_LW/LH/LHU/LB/LBU (3-bit) constants.
  - REG_ZERO=5'd0.
- One combinational sub-module, load_formatter:
  - inputs: raw word, addr_lo, load_type.
  - outputs: formatted word, misalign flag.
- Pipeline register, mux, enable logic and counter live in wb_stage.

Test Plan:
- Reset then ALU op: dest=8, sel=0, alu=0x0000_1234, reg_write=1 -> next cycle WB_A3=8, WB_WD3=0x1234, WB_WE3=1, retire_cnt 0->1 on following edge.
- Loads with rdata=0x80FF_7F01:
  - LB addr_lo=3 -> 0xFFFF_FF80.
  - LBU addr_lo=1 -> 0x0000_007F.
  - LH addr_lo=2 -> 0xFFFF_80FF.
  - LHU addr_lo=0 -> 0x0000_7F01.
  - LW addr_lo=0 -> 0x80FF_7F01.
- Misalign: LW addr_lo=2 -> misalign_err=1, WB_WE3=0, retire_cnt still increments; LH addr_lo=1 -> same.
- dest=0 ALU write -> WB_WE3=0. JAL (sel=2, dest=31, pc_plus8=0x0040_0008) -> WB_WD3=0x0040_0008, WB_WE3=1.
- STALL held 3 cycles with valid entry -> outputs constant, WB_WE3=1, retire_cnt unchanged. STALL=1 and FLUSH=1 together -> wb_valid=0, WB_WE3=0 next cycle.
- Preload retire_cnt near wrap (CNT_W=4 instance, 15 retires) -> 16th retire gives 0. RESET pulsed asynchronously between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and the MEM/WB pipeline entry layout for the 5-stage MIPS datapath.
package mips_pkg;
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;
    localparam logic [1:0] WB_SEL_RSVD = 2'd3;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  dest;
        logic [1:0]  wb_sel;
        logic [2:0]  load_type;
        logic [1:0]  addr_lo;
        logic [31:0] alu_result;
        logic [31:0] mem_rdata;
        logic [31:0] pc_plus8;
    } wb_entry_t;
endpackage

// File: rtl/load_formatter.sv
// Little-endian byte/halfword extraction with sign or zero extension and alignment check.
module load_formatter
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_type,
    output logic [31:0] data,
    output logic        misalign
);
    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (load_type)
            LD_LW:  begin data = rdata;                           misalign = (addr_lo != 2'd0); end
            LD_LH:  begin data = {{16{half[15]}}, half};          misalign = addr_lo[0];        end
            LD_LHU: begin data = {16'h0, half};                   misalign = addr_lo[0];        end
            LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: data = {24'h0, byte_sel};
            // Reserved encodings are treated as faulting loads so they never write back.
            default: misalign = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback source mux, register-file write enable and retire counter.
module wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic [4:0]        in_dest,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_load_type,
    input  logic [1:0]        in_addr_lo,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_rdata,
    input  logic [DATA_W-1:0] in_pc_plus8,
    output logic [4:0]        WB_A3,
    output logic [DATA_W-1:0] WB_WD3,
    output logic              WB_WE3,
    output logic              wb_valid,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  retire_cnt
);
    wb_entry_t   ent;
    logic [31:0] fmt_data;
    logic        fmt_misalign;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ent <= '0;
        end else if (FLUSH) begin
            ent.valid     <= 1'b0;
            ent.reg_write <= 1'b0;
        end else if (!STALL) begin
            ent <= '{valid: in_valid, reg_write: in_reg_write, dest: in_dest,
                     wb_sel: in_wb_sel, load_type: in_load_type, addr_lo: in_addr_lo,
                     alu_result: in_alu_result, mem_rdata: in_mem_rdata,
                     pc_plus8: in_pc_plus8};
        end
    end

    // The held instruction committed on the falling edge already, so a flush does not un-retire it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                   retire_cnt <= '0;
        else if (ent.valid && !STALL) retire_cnt <= retire_cnt + CNT_W'(1);
    end

    load_formatter u_fmt (
        .rdata     (ent.mem_rdata),
        .addr_lo   (ent.addr_lo),
        .load_type (ent.load_type),
        .data      (fmt_data),
        .misalign  (fmt_misalign)
    );

    always_comb begin
        case (ent.wb_sel)
            WB_SEL_ALU:  WB_WD3 = ent.alu_result;
            WB_SEL_MEM:  WB_WD3 = fmt_data;
            WB_SEL_LINK: WB_WD3 = ent.pc_plus8;
            default:     WB_WD3 = '0;
        endcase
    end

    assign wb_valid     = ent.valid;
    assign WB_A3        = ent.dest;
    assign misalign_err = ent.valid && (ent.wb_sel == WB_SEL_MEM) && fmt_misalign;
    assign WB_WE3       = ent.valid && ent.reg_write && (ent.dest != REG_ZERO)
                          && !misalign_err && (ent.wb_sel != WB_SEL_RSVD);
endmodule
